// File: rtl/uart_pkg.sv
// Shared constants, state encoding and helpers for the parametrised UART core.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Received character with its line-error flags, delivered as one word.
  typedef struct packed {
    logic [7:0] data;
    logic       frame_err;
    logic       parity_err;
  } rx_word_t;

  function automatic logic [7:0] data_mask(input int unsigned bits);
    return 8'((9'h1 << bits) - 9'h1);
  endfunction

  // Expects data already masked to the configured width.
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_core_param_baud_tick.sv
// Free-running divider: one-clock tick every DIV clocks, shared by TX and RX.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART with configurable framing, valid/ready client ports,
// 16x-oversampled receive with start-bit glitch rejection and error reporting.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_parity_err,
  output logic       rx_overrun
);

  localparam int unsigned DIV         = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned SHIFT_ALIGN = 8 - DATA_BITS;
  localparam logic [7:0]  MASK        = data_mask(DATA_BITS);
  localparam logic [3:0]  TICK_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]  TICK_MID    = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]  DATA_LAST   = 3'(DATA_BITS - 1);
  localparam logic [2:0]  STOP_LAST   = 3'(STOP_BITS - 1);

  logic tick;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // ---------------------------------------------------------------- TX
  uart_state_e tx_state, tx_state_nxt;
  logic [3:0]  tx_tick_cnt, tx_tick_cnt_nxt;
  logic [2:0]  tx_bit_cnt, tx_bit_cnt_nxt;
  logic [7:0]  tx_shift, tx_shift_nxt;
  logic        tx_par, tx_par_nxt;
  logic        tx_nxt, tx_ready_nxt;
  logic        tx_accept, tx_bit_end;

  assign tx_accept  = tx_valid && tx_ready;
  assign tx_bit_end = tick && (tx_tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state    <= ST_IDLE;
      tx_tick_cnt <= '0;
      tx_bit_cnt  <= '0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      tx          <= 1'b1;
      tx_ready    <= 1'b1;
      tx_busy     <= 1'b0;
    end else begin
      tx_state    <= tx_state_nxt;
      tx_tick_cnt <= tx_tick_cnt_nxt;
      tx_bit_cnt  <= tx_bit_cnt_nxt;
      tx_shift    <= tx_shift_nxt;
      tx_par      <= tx_par_nxt;
      tx          <= tx_nxt;
      tx_ready    <= tx_ready_nxt;
      tx_busy     <= ~tx_ready_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      ST_IDLE:   if (tx_accept) tx_state_nxt = ST_START;
      ST_START:  if (tx_bit_end) tx_state_nxt = ST_DATA;
      ST_DATA:   if (tx_bit_end && (tx_bit_cnt == DATA_LAST))
                   tx_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tx_bit_end) tx_state_nxt = ST_STOP;
      ST_STOP:   if (tx_bit_end && (tx_bit_cnt == STOP_LAST)) tx_state_nxt = ST_IDLE;
      default:   tx_state_nxt = ST_IDLE;
    endcase
  end

  // Line level is computed for the state being entered so tx changes with the state.
  always_comb begin
    tx_tick_cnt_nxt = tx_tick_cnt;
    tx_bit_cnt_nxt  = tx_bit_cnt;
    tx_shift_nxt    = tx_shift;
    tx_par_nxt      = tx_par;
    tx_nxt          = 1'b1;
    tx_ready_nxt    = (tx_state_nxt == ST_IDLE);

    if (tx_state == ST_IDLE) tx_tick_cnt_nxt = '0;
    else if (tick)           tx_tick_cnt_nxt = tx_tick_cnt + 4'd1;

    if (tx_accept) begin
      tx_shift_nxt = tx_data & MASK;
      tx_par_nxt   = parity_bit(tx_data & MASK, PARITY);
    end

    if (tx_bit_end) begin
      tx_bit_cnt_nxt = (tx_state_nxt == tx_state) ? tx_bit_cnt + 3'd1 : 3'd0;
      if (tx_state == ST_DATA) tx_shift_nxt = tx_shift >> 1;
    end

    case (tx_state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = tx_shift_nxt[0];
      ST_PARITY: tx_nxt = tx_par;
      default:   tx_nxt = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- RX
  logic        rx_meta, rx_sync;
  uart_state_e rx_state, rx_state_nxt;
  logic [3:0]  rx_tick_cnt, rx_tick_cnt_nxt;
  logic [2:0]  rx_bit_cnt, rx_bit_cnt_nxt;
  logic [7:0]  rx_shift, rx_shift_nxt;
  logic        rx_par_sample, rx_par_sample_nxt;
  logic        rx_armed, rx_armed_nxt;
  rx_word_t    rx_word, rx_word_nxt;
  logic        rx_valid_nxt, rx_overrun_nxt;
  logic        rx_sample, rx_done, rx_par_err;
  logic [7:0]  rx_frame_data;

  assign rx_sample     = tick && (rx_tick_cnt == ((rx_state == ST_START) ? TICK_MID : TICK_LAST));
  assign rx_done       = (rx_state == ST_STOP) && rx_sample;
  assign rx_frame_data = 8'(rx_shift >> SHIFT_ALIGN) & MASK;
  assign rx_par_err    = (PARITY != PAR_NONE) &&
                         (rx_par_sample != parity_bit(rx_frame_data, PARITY));

  assign rx_data       = rx_word.data;
  assign rx_frame_err  = rx_word.frame_err;
  assign rx_parity_err = rx_word.parity_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_state      <= ST_IDLE;
      rx_tick_cnt   <= '0;
      rx_bit_cnt    <= '0;
      rx_shift      <= '0;
      rx_par_sample <= 1'b0;
      rx_armed      <= 1'b1;
      rx_word       <= '0;
      rx_valid      <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_meta       <= rx;
      rx_sync       <= rx_meta;
      rx_state      <= rx_state_nxt;
      rx_tick_cnt   <= rx_tick_cnt_nxt;
      rx_bit_cnt    <= rx_bit_cnt_nxt;
      rx_shift      <= rx_shift_nxt;
      rx_par_sample <= rx_par_sample_nxt;
      rx_armed      <= rx_armed_nxt;
      rx_word       <= rx_word_nxt;
      rx_valid      <= rx_valid_nxt;
      rx_overrun    <= rx_overrun_nxt;
    end
  end

  // A start bit still low at half a bit is real; otherwise treat it as a glitch.
  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      ST_IDLE:   if (rx_armed && !rx_sync) rx_state_nxt = ST_START;
      ST_START:  if (rx_sample) rx_state_nxt = rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA:   if (rx_sample && (rx_bit_cnt == DATA_LAST))
                   rx_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (rx_sample) rx_state_nxt = ST_STOP;
      ST_STOP:   if (rx_sample) rx_state_nxt = ST_IDLE;
      default:   rx_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_tick_cnt_nxt   = rx_tick_cnt;
    rx_bit_cnt_nxt    = rx_bit_cnt;
    rx_shift_nxt      = rx_shift;
    rx_par_sample_nxt = rx_par_sample;
    rx_armed_nxt      = rx_armed;
    rx_word_nxt       = rx_word;
    rx_valid_nxt      = rx_valid && !rx_ready;
    rx_overrun_nxt    = 1'b0;

    if ((rx_state == ST_IDLE) || rx_sample) rx_tick_cnt_nxt = '0;
    else if (tick)                          rx_tick_cnt_nxt = rx_tick_cnt + 4'd1;

    if (rx_state != ST_DATA) rx_bit_cnt_nxt = '0;
    else if (rx_sample)      rx_bit_cnt_nxt = rx_bit_cnt + 3'd1;

    if ((rx_state == ST_DATA) && rx_sample)   rx_shift_nxt = {rx_sync, rx_shift[7:1]};
    if ((rx_state == ST_PARITY) && rx_sample) rx_par_sample_nxt = rx_sync;

    // After a low stop bit (break), wait for the line to go idle before re-arming.
    if (rx_done)                             rx_armed_nxt = rx_sync;
    else if ((rx_state == ST_IDLE) && rx_sync) rx_armed_nxt = 1'b1;

    if (rx_done) begin
      if (rx_valid && !rx_ready) begin
        rx_overrun_nxt = 1'b1;
      end else begin
        rx_valid_nxt = 1'b1;
        rx_word_nxt  = '{data: rx_frame_data, frame_err: ~rx_sync, parity_err: rx_par_err};
      end
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: three configurations (8N1, 7E1, 8N2) with a
// scoreboard on the receive side and directed checks on the transmit line.
module tb_uart_core_param;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned BAUD    = 1_562_500;
  localparam int          BIT_CLK = 32;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst;
  logic       tx [3];
  logic       rx [3];
  logic       loop [3];
  logic       drv [3];
  logic [7:0] tx_data [3];
  logic       tx_valid [3];
  logic       tx_ready [3];
  logic       tx_busy [3];
  logic [7:0] rx_data [3];
  logic       rx_valid [3];
  logic       rx_ready [3];
  logic       fe [3];
  logic       pe [3];
  logic       ov [3];

  assign rx[0] = loop[0] ? tx[0] : drv[0];
  assign rx[1] = loop[1] ? tx[1] : drv[1];
  assign rx[2] = loop[2] ? tx[2] : drv[2];

  uart_core_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .rx(rx[0]), .tx(tx[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx_busy(tx_busy[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .rx_ready(rx_ready[0]), .rx_frame_err(fe[0]), .rx_parity_err(pe[0]), .rx_overrun(ov[0]));

  uart_core_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .rx(rx[1]), .tx(tx[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx_busy(tx_busy[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .rx_ready(rx_ready[1]), .rx_frame_err(fe[1]), .rx_parity_err(pe[1]), .rx_overrun(ov[1]));

  uart_core_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .rx(rx[2]), .tx(tx[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx_busy(tx_busy[2]), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
    .rx_ready(rx_ready[2]), .rx_frame_err(fe[2]), .rx_parity_err(pe[2]), .rx_overrun(ov[2]));

  int checks = 0;
  int errors = 0;
  int ov_cycles = 0;
  rx_word_t exp_q0 [$];
  rx_word_t exp_q1 [$];
  rx_word_t w0, w1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_word(input string p, input logic [7:0] d, input logic f, input logic q,
                          input rx_word_t w);
    chk({p, "_rx_data"}, 32'(d), 32'(w.data));
    chk({p, "_frame_err"}, 32'(f), 32'(w.frame_err));
    chk({p, "_parity_err"}, 32'(q), 32'(w.parity_err));
  endtask

  task automatic expect_rx(input int d, input logic [7:0] data, input logic f, input logic q);
    rx_word_t w;
    w = '{data: data, frame_err: f, parity_err: q};
    if (d == 0) exp_q0.push_back(w);
    else        exp_q1.push_back(w);
  endtask

  // Monitor: every consumed receive word is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid[0] && rx_ready[0]) begin
        if (exp_q0.size() == 0) chk("dut0_unexpected_rx_valid", 32'd1, 32'd0);
        else begin
          w0 = exp_q0.pop_front();
          cmp_word("dut0", rx_data[0], fe[0], pe[0], w0);
        end
      end
      if (rx_valid[1] && rx_ready[1]) begin
        if (exp_q1.size() == 0) chk("dut1_unexpected_rx_valid", 32'd1, 32'd0);
        else begin
          w1 = exp_q1.pop_front();
          cmp_word("dut1", rx_data[1], fe[1], pe[1], w1);
        end
      end
      if (ov[0]) ov_cycles++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Returns 2 ns after the accepting edge.
  task automatic send_byte(input int d, input logic [7:0] data);
    int n;
    n = 0;
    while (!tx_ready[d] && n < 2000) begin
      cyc(1);
      n++;
    end
    chk("tx_ready_timeout", 32'(tx_ready[d]), 32'd1);
    tx_data[d]  = data;
    tx_valid[d] = 1'b1;
    cyc(1);
    tx_valid[d] = 1'b0;
  endtask

  // Sample the line at mid-bit, bit 0 being the start bit.
  task automatic check_tx_frame(input int d, input logic [15:0] bits, input int n);
    cyc(16);
    chk("tx_busy_in_frame", 32'(tx_busy[d]), 32'd1);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("dut%0d_tx_bit%0d", d, i), 32'(tx[d]), 32'(bits[i]));
      cyc(BIT_CLK);
    end
  endtask

  task automatic drive_rx_bits(input int d, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      drv[d] = bits[i];
      cyc(BIT_CLK);
    end
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while (((d == 0) ? exp_q0.size() : exp_q1.size()) > 0 && n < 1500) begin
      cyc(1);
      n++;
    end
    chk($sformatf("dut%0d_scoreboard_drain", d), 32'((d == 0) ? exp_q0.size() : exp_q1.size()), 32'd0);
  endtask

  task automatic watch_no_valid(input string name, input int d, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      cyc(1);
      if (rx_valid[d]) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n, high;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      loop[i] = 1'b1;
      drv[i] = 1'b1;
      tx_data[i] = 8'h00;
      tx_valid[i] = 1'b0;
      rx_ready[i] = 1'b1;
    end
    cyc(5);
    chk("reset_tx", 32'(tx[0]), 32'd1);
    chk("reset_tx_ready", 32'(tx_ready[0]), 32'd1);
    chk("reset_tx_busy", 32'(tx_busy[0]), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid[0]), 32'd0);
    chk("reset_rx_data", 32'(rx_data[0]), 32'd0);
    chk("reset_frame_err", 32'(fe[0]), 32'd0);
    chk("reset_parity_err", 32'(pe[0]), 32'd0);
    chk("reset_overrun", 32'(ov[0]), 32'd0);
    rst = 1'b0;
    cyc(5);

    // 8N1 loopback of A5: line 0,1,0,1,0,0,1,0,1,1
    expect_rx(0, 8'hA5, 1'b0, 1'b0);
    send_byte(0, 8'hA5);
    check_tx_frame(0, 16'h034A, 10);
    wait_drain(0);

    // 7E1 loopback of FF: seven ones, even parity bit 1, data reads back 7F
    expect_rx(1, 8'h7F, 1'b0, 1'b0);
    send_byte(1, 8'hFF);
    check_tx_frame(1, 16'h03FE, 10);
    wait_drain(1);
    loop[1] = 1'b0;
    cyc(4);
    expect_rx(1, 8'h7F, 1'b0, 1'b1);
    drive_rx_bits(1, 16'h02FE, 10);
    wait_drain(1);
    loop[1] = 1'b1;

    // 8-clock low glitch is rejected, then a clean 3C frame
    loop[0] = 1'b0;
    cyc(4);
    drv[0] = 1'b0;
    cyc(8);
    drv[0] = 1'b1;
    watch_no_valid("glitch_no_rx_valid", 0, 96);
    expect_rx(0, 8'h3C, 1'b0, 1'b0);
    drive_rx_bits(0, 16'h0278, 10);
    wait_drain(0);

    // Overrun: second frame dropped while the first is held
    loop[0] = 1'b1;
    rx_ready[0] = 1'b0;
    cyc(4);
    expect_rx(0, 8'h11, 1'b0, 1'b0);
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    n = 0;
    while (ov_cycles == 0 && n < 1000) begin
      cyc(1);
      n++;
    end
    cyc(4);
    chk("overrun_pulse_width", 32'(ov_cycles), 32'd1);
    chk("overrun_valid_held", 32'(rx_valid[0]), 32'd1);
    chk("overrun_data_kept", 32'(rx_data[0]), 32'h11);
    rx_ready[0] = 1'b1;
    cyc(1);
    chk("valid_cleared_after_consume", 32'(rx_valid[0]), 32'd0);
    wait_drain(0);

    // Low stop bit gives data plus frame error; a held break yields nothing more
    loop[0] = 1'b0;
    drv[0] = 1'b1;
    cyc(8);
    expect_rx(0, 8'h55, 1'b1, 1'b0);
    drive_rx_bits(0, 16'h00AA, 10);
    chk("break_frame_consumed", 32'(exp_q0.size()), 32'd0);
    watch_no_valid("break_no_rx_valid", 0, 3 * 10 * BIT_CLK);
    drv[0] = 1'b1;
    cyc(64);
    expect_rx(0, 8'hC3, 1'b0, 1'b0);
    drive_rx_bits(0, 16'h0386, 10);
    wait_drain(0);
    loop[0] = 1'b1;

    // Reset in the middle of data bit 3 on the 8N2 instance
    send_byte(2, 8'h96);
    cyc(16 + 4 * BIT_CLK - 1);
    chk("mid_bit3_line", 32'(tx[2]), 32'd0);
    rst = 1'b1;
    cyc(1);
    chk("rst_mid_frame_tx", 32'(tx[2]), 32'd1);
    chk("rst_mid_frame_tx_ready", 32'(tx_ready[2]), 32'd1);
    chk("rst_mid_frame_tx_busy", 32'(tx_busy[2]), 32'd0);
    rst = 1'b0;
    cyc(4);

    // Two stop bits: the high run between back-to-back zero bytes
    send_byte(2, 8'h00);
    high = 0;
    fork
      send_byte(2, 8'h00);
      begin
        n = 0;
        while (tx[2] == 1'b0 && n < 1000) begin
          cyc(1);
          n++;
        end
        while (tx[2] == 1'b1 && high < 1000) begin
          cyc(1);
          high++;
        end
      end
    join
    chk("stop2_high_at_least_64", 32'(high >= 64), 32'd1);
    chk("stop2_high_no_idle_gap", 32'(high <= 65), 32'd1);
    cyc(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
